// File: rtl/rec_lane_packer.sv
// Purpose : gather serial 8-bit {adr,val} records into a packed vector of LANES records (lane 0 in LSBs).
// Latency : last record accepted at edge t sets asm_full at t; out_valid rises after edge t+1.
// Backpr. : in_ready = !asm_full; the output register holds under out_ready=0 while assembly keeps filling.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     record input handshake, in_rec = {adr[3:0], val[3:0]}
//   flush                 emit partially filled vector (only when REC_PACK_FLUSH_EN is defined)
//   out_valid/out_ready   vector output handshake
//   out_vec               packed lanes, lane k at [8k+7:8k]
//   out_count             number of valid lanes in out_vec
//
// Optional feature macro: REC_PACK_FLUSH_EN (adds the flush port and partial-vector emission).
module rec_lane_packer #(
    parameter int          LANES = 4,
    parameter logic [7:0]  FILL  = 8'h00
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [7:0]                   in_rec,
`ifdef REC_PACK_FLUSH_EN
    input  logic                         flush,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [8*LANES-1:0]           out_vec,
    output logic [$clog2(LANES+1)-1:0]   out_count
);

    localparam int IW = $clog2(LANES);
    localparam int CW = $clog2(LANES+1);
    localparam logic [IW-1:0] LAST = IW'(LANES-1);

    logic [LANES-1:0][7:0] asm_q;
    logic [IW-1:0]         idx_q;
    logic                  asm_full_q;
    logic [CW-1:0]         asm_cnt_q;

    logic accept;
    logic transfer;
    logic do_flush;

    // in_ready depends on registered state only, so upstream sees no combinational path.
    assign in_ready = !asm_full_q;
    assign accept   = in_valid && in_ready;
    // accept and transfer are mutually exclusive (accept needs !asm_full), so
    // clearing the assembly on transfer never collides with a lane write.
    assign transfer = asm_full_q && (!out_valid || out_ready);

`ifdef REC_PACK_FLUSH_EN
    // Flush only matters when something is (or is being) assembled and the
    // vector is not already complete.
    assign do_flush = flush && !asm_full_q && ((idx_q != '0) || accept);
`else
    assign do_flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q      <= {LANES{FILL}};
            idx_q      <= '0;
            asm_full_q <= 1'b0;
            asm_cnt_q  <= '0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_count  <= '0;
        end else begin
            if (transfer) begin
                out_vec    <= asm_q;
                out_count  <= asm_cnt_q;
                out_valid  <= 1'b1;
                asm_full_q <= 1'b0;
                asm_q      <= {LANES{FILL}};
            end else if (out_valid && out_ready) begin
                // out_vec/out_count keep their last value after the drain
                out_valid  <= 1'b0;
            end

            if (accept) begin
                asm_q[idx_q] <= in_rec;
                if (idx_q == LAST) begin
                    idx_q      <= '0;
                    asm_full_q <= 1'b1;
                    asm_cnt_q  <= CW'(LANES);
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end

            // A same-cycle record is counted in the lane total; when that record
            // completes the vector the result equals the normal full case.
            if (do_flush) begin
                idx_q      <= '0;
                asm_full_q <= 1'b1;
                asm_cnt_q  <= CW'(idx_q) + CW'(accept);
            end
        end
    end

endmodule

// File: tb/tb_rec_lane_packer.sv
// Purpose : randomized and directed checks of rec_lane_packer against a queue-based record model.
// Latency : n/a (bench).
// Backpr. : bench drives random out_ready stalls.
module tb_rec_lane_packer;

    localparam int         LANES = 4;
    localparam int         CW    = $clog2(LANES+1);
    localparam logic [7:0] FILL_V = 8'hFF;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          in_rec;
    logic                out_valid;
    logic                out_ready;
    logic [8*LANES-1:0]  out_vec;
    logic [CW-1:0]       out_count;
`ifdef REC_PACK_FLUSH_EN
    logic                flush;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_vec = 0;

    rec_lane_packer #(.LANES(LANES), .FILL(FILL_V)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rec    (in_rec),
`ifdef REC_PACK_FLUSH_EN
        .flush     (flush),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model: records -> vectors ----------------
    typedef struct packed {
        logic [31:0] v;
        logic [7:0]  c;
    } exp_t;

    logic [7:0]  part_q[$];
    exp_t        exp_q[$];
    logic        stall_prev;
    logic [31:0] prev_vec;

    function automatic exp_t mk_vec();
        exp_t e;
        e.v = {LANES{FILL_V}};
        foreach (part_q[i]) e.v[8*i +: 8] = part_q[i];
        e.c = 8'(part_q.size());
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            part_q.delete();
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_vec", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_vec", out_vec, e.v);
                    chk("sb_cnt", 32'(out_count), 32'(e.c));
                    n_vec++;
                end
            end
            if (stall_prev) begin
                chk("hold_vld", 32'(out_valid), 32'd1);
                chk("hold_vec", out_vec, prev_vec);
            end
            stall_prev = out_valid && !out_ready;
            prev_vec   = out_vec;
            if (in_valid && in_ready) begin
                part_q.push_back(in_rec);
                if (part_q.size() == LANES) begin
                    exp_q.push_back(mk_vec());
                    part_q.delete();
                end
            end
`ifdef REC_PACK_FLUSH_EN
            if (flush && in_ready && part_q.size() > 0) begin
                exp_q.push_back(mk_vec());
                part_q.delete();
            end
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] r);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_rec   = r;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        in_rec   = '0;
    endtask

    task automatic stream(input int first, input int cnt, input int maxcyc,
                          output int acc, output int lows);
        int c;
        acc = 0; lows = 0; c = 0;
        in_valid = 1'b1;
        in_rec   = 8'(first);
        while (acc < cnt && c < maxcyc) begin
            @(negedge clk);
            if (in_ready) acc++;
            else          lows++;
            c++;
            cyc();
            in_rec = 8'(first + acc);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_vec(input string tag, input logic [31:0] v, input int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_vld"}, 32'(out_valid), 32'd1);
        chk({tag, "_vec"}, out_vec, v);
        chk({tag, "_cnt"}, 32'(out_count), 32'(c));
        cyc();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lows, hi;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_rec    = '0;
        out_ready = 1'b1;
`ifdef REC_PACK_FLUSH_EN
        flush     = 1'b0;
`endif
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_vec",   out_vec,        32'd0);
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();

        // T2: back-to-back stream with free output
        stream(0, 12, 100, acc, lows);
        chk("t2_accepted", 32'(acc), 32'd12);
        chk("t2_bubbles",  32'(lows), 32'd2);
        repeat (4) cyc();
        chk("t2_vectors", 32'(n_vec), 32'd3);

        // T1: held vector plus partial assembly, then async reset
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        chk("t1_pre_vld", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_vld",   32'(out_valid), 32'd0);
        chk("t1_rst_rdy",   32'(in_ready),  32'd1);
        chk("t1_rst_cnt",   32'(out_count), 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        out_ready = 1'b1;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        chk("t1_no_emit", 32'(hi), 32'd0);
        cyc();
        push(8'h10); push(8'h21); push(8'h32); push(8'h43);
        @(negedge clk);
        chk("t1_lat0", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat1", 32'(out_valid), 32'd1);
        chk("t1_vec",  out_vec, 32'h43322110);
        chk("t1_cnt",  32'(out_count), 32'd4);
        repeat (2) cyc();

        // T3: output backpressure
        out_ready = 1'b0;
        stream(0, 4, 20, acc, lows);
        stream(4, 8, 20, acc, lows);
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_in_ready", 32'(in_ready), 32'd0);
        chk("t3_held_vec", out_vec, 32'h03020100);
        out_ready = 1'b1;
        stream(8, 4, 50, acc, lows);
        chk("t3_rest", 32'(acc), 32'd4);
        repeat (4) cyc();

        // T4: unknown bits pass through unchanged
        push(8'hx0); push(8'hx1); push(8'hx2); push(8'hx3);
        expect_vec("t4", 32'hx3x2x1x0, 4);
        repeat (2) cyc();

`ifdef REC_PACK_FLUSH_EN
        // T5: flush partial, then flush an empty assembly
        push(8'hA5); push(8'h5A);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        expect_vec("t5", {FILL_V, FILL_V, 8'h5A, 8'hA5}, 2);
        repeat (2) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        chk("t5_empty_flush", 32'(hi), 32'd0);
        cyc();

        // T6: flush in the same cycle as the third accept
        push(8'h11); push(8'h22);
        in_valid = 1'b1;
        in_rec   = 8'h33;
        flush    = 1'b1;
        cyc();
        in_valid = 1'b0;
        flush    = 1'b0;
        expect_vec("t6", {FILL_V, 8'h33, 8'h22, 8'h11}, 3);
        repeat (2) cyc();
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(99) < 60);
            in_rec    = 8'($urandom);
            out_ready = ($urandom_range(99) < 55);
`ifdef REC_PACK_FLUSH_EN
            flush     = ($urandom_range(99) < 8);
`endif
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef REC_PACK_FLUSH_EN
        flush = 1'b0;
        repeat (4) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
`endif
        repeat (10) cyc();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
`ifdef REC_PACK_FLUSH_EN
        chk("sb_partial", 32'(part_q.size()), 32'd0);
`endif
        chk("final_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
